// File: rtl/sram1_arbiter.sv
// Round-robin two-port arbiter and single-word sequencer for the 8x8 sram1 array.
// One request is served at a time: CMD drives the bus for one cycle; reads wait one more cycle for data_out.
module sram1_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CMD, RWAIT} state_t;

    state_t state, state_nxt;
    logic   last;     // port granted most recently
    logic   win;      // port owning the current operation
    logic   we_q;
    logic   any_req;
    logic   pick;

    always_comb begin
        any_req = p0_req | p1_req;
        // port 1 wins when alone, or on a tie when port 0 was served last
        pick    = p1_req & (~p0_req | ~last);
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = CMD;
            CMD:     state_nxt = we_q ? IDLE : RWAIT;
            RWAIT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        p0_gnt = (state == CMD) & ~win;
        p1_gnt = (state == CMD) &  win;
        busy   = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            win       <= 1'b0;
            we_q      <= 1'b0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_add   <= '0;
            mem_din   <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            if (state == IDLE && any_req) begin
                win     <= pick;
                last    <= pick;
                we_q    <= pick ? p1_we : p0_we;
                mem_add <= pick ? p1_addr : p0_addr;
                mem_din <= pick ? p1_wdata : p0_wdata;
                mem_wr  <= pick ? p1_we : p0_we;
                mem_rd  <= pick ? ~p1_we : ~p0_we;
            end
            if (state == RWAIT) begin
                if (win) begin
                    p1_rdata  <= mem_dout;
                    p1_rvalid <= 1'b1;
                end else begin
                    p0_rdata  <= mem_dout;
                    p0_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram1_arbiter.sv
// Randomized bench for sram1_arbiter with an sram1 model and a transaction-timing reference model.
module tb_sram1_arbiter;
    localparam int NCYC = 1800;
    localparam int PH   = 600;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [7:0] p0_rdata, p1_rdata;
    logic       mem_wr, mem_rd, busy;
    logic [2:0] mem_add;
    logic [7:0] mem_din;
    logic [7:0] mem_dout = 8'h00;

    bit       r_req [2];
    bit       r_we  [2];
    bit [2:0] r_addr[2];
    bit [7:0] r_wd  [2];

    sram1_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(r_req[0]), .p0_we(r_we[0]), .p0_addr(r_addr[0]), .p0_wdata(r_wd[0]),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(r_req[1]), .p1_we(r_we[1]), .p1_addr(r_addr[1]), .p1_wdata(r_wd[1]),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_add(mem_add), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // sram1 behaviour
    logic [7:0] mem [8];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_add] <= mem_din;
        if (mem_rd) mem_dout <= mem[mem_add];
    end

    // expected per-cycle events, indexed by cycle number after an edge
    bit [1:0] e_gnt [NCYC+8];
    bit       e_wr  [NCYC+8];
    bit       e_rd  [NCYC+8];
    bit       e_busy[NCYC+8];
    bit [1:0] e_rv  [NCYC+8];
    bit [7:0] e_rdv [NCYC+8];
    bit [2:0] e_add [NCYC+8];
    bit [7:0] e_din [NCYC+8];
    bit [7:0] ref_mem [8];
    bit [7:0] m_rdata [2];
    bit [2:0] m_add;
    bit [7:0] m_din;
    int       last, free;
    int       checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp, input int cyc);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic new_txn(input int p);
        r_req[p]  = 1'b1;
        r_we[p]   = 1'($urandom_range(0, 1));
        r_addr[p] = 3'($urandom_range(0, 7));
        r_wd[p]   = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int rate[2];
        int w;
        bit [1:0] gs;
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 8'(i * 17 + 3);
            ref_mem[i] = 8'(i * 17 + 3);
        end
        last = 1;
        free = 0;
        rst_n = 1'b0;
        // both ports already requesting while reset is held
        r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 3'd3; r_wd[0] = 8'h11;
        r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 3'd3; r_wd[1] = 8'h22;

        for (int c = 1; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_add = '0; m_din = '0; m_rdata[0] = '0; m_rdata[1] = '0;
            end
            if (e_wr[c] || e_rd[c]) begin
                m_add = e_add[c];
                m_din = e_din[c];
            end
            for (int p = 0; p < 2; p++)
                if (e_rv[c][p]) m_rdata[p] = e_rdv[c];

            if (c >= 2) begin
                chk("gnt",    {p1_gnt, p0_gnt},       e_gnt[c],   c);
                chk("mem_wr", mem_wr,                 e_wr[c],    c);
                chk("mem_rd", mem_rd,                 e_rd[c],    c);
                chk("excl",   mem_wr & mem_rd,        0,          c);
                chk("busy",   busy,                   e_busy[c],  c);
                chk("rvalid", {p1_rvalid, p0_rvalid}, e_rv[c],    c);
                chk("mem_add", mem_add,               m_add,      c);
                chk("mem_din", mem_din,               m_din,      c);
                chk("p0_rdata", p0_rdata,             m_rdata[0], c);
                chk("p1_rdata", p1_rdata,             m_rdata[1], c);
            end

            case (c / PH)
                0:       begin rate[0] = 100; rate[1] = 0;   end
                1:       begin rate[0] = 100; rate[1] = 100; end
                default: begin rate[0] = 60;  rate[1] = 50;  end
            endcase

            if (c >= 3) rst_n = 1'b1;

            gs = {p1_gnt, p0_gnt};
            if (c >= 3) begin
                for (int p = 0; p < 2; p++) begin
                    if (gs[p]) begin
                        if ($urandom_range(0, 99) < rate[p]) new_txn(p);
                        else r_req[p] = 1'b0;
                    end else if (!r_req[p] && $urandom_range(0, 99) < rate[p]) begin
                        new_txn(p);
                    end
                end
            end

            // occasional reset while an operation is in flight
            if (c / PH >= 2 && rst_n && e_busy[c] && $urandom_range(0, 5) == 0) begin
                rst_n = 1'b0;
                for (int i = c + 1; i <= c + 4; i++) begin
                    e_gnt[i] = '0; e_wr[i] = 0; e_rd[i] = 0; e_busy[i] = 0; e_rv[i] = '0;
                end
                last = 1;
                free = 0;
            end

            if (rst_n && c >= free && (r_req[0] || r_req[1])) begin
                if (r_req[0] && r_req[1]) w = (last == 1) ? 0 : 1;
                else w = r_req[0] ? 0 : 1;
                last = w;
                e_gnt[c+1][w] = 1'b1;
                e_busy[c+1]   = 1'b1;
                e_add[c+1]    = r_addr[w];
                e_din[c+1]    = r_wd[w];
                if (r_we[w]) begin
                    e_wr[c+1] = 1'b1;
                    ref_mem[r_addr[w]] = r_wd[w];
                    free = c + 2;
                end else begin
                    e_rd[c+1]    = 1'b1;
                    e_busy[c+2]  = 1'b1;
                    e_rv[c+3][w] = 1'b1;
                    e_rdv[c+3]   = ref_mem[r_addr[w]];
                    free = c + 3;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
